// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state encoding, PS/2 prefix bytes and arrow-key scan codes.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;
    localparam logic [7:0] KEY_UP = 8'h75;
    localparam logic [7:0] KEY_DOWN = 8'h72;
    localparam logic [7:0] KEY_LEFT = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [31:0] ARROW_CODES = {KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP};
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: first-word-fall-through event queue with sticky drop flag.
module ps2_evt_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             overflow
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr, rd;
    logic full, take, put;
    assign valid = wr != rd;
    assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
    assign take = pop && valid;
    assign put = push && (!full || take);
    assign dout = mem[rd[AW-1:0]];
    always_ff @(posedge clk)
        if (put) mem[wr[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
            overflow <= 1'b0;
        end else begin
            wr <= wr + (AW+1)'(put);
            rd <= rd + (AW+1)'(take);
            overflow <= overflow || (push && full && !take);
        end
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 receiver that decodes make/break frames into a held-key
// bitmap, a most-recent active key and a queue of press/release events.
module ps2_key_tracker import ps2_pkg::*; #(
    parameter int CLK_HZ = 100_000_000,
    parameter int NUM_KEYS = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES = ARROW_CODES,
    parameter logic [NUM_KEYS-1:0] EXT_MASK = '1,
    parameter int TIMEOUT_US = 100,
    parameter int FIFO_DEPTH = 8,
    localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                active_valid,
    output logic [KW-1:0]       active_key,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [KW-1:0]       event_key,
    output logic                event_make,
    output logic                frame_err,
    output logic                overflow
);
    localparam int TO = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW = $clog2(TO + 1);
    logic [1:0] clk_sy, dat_sy;
    logic [5:0] hist;
    logic fall, ps2d;
    rx_state_t state, state_n;
    logic [2:0] bit_cnt;
    logic [7:0] sh;
    logic par_b, err, done, tmo, rx_valid, ext, brk;
    logic [TW-1:0] tmr;
    logic hit, is_key, mk, bk, push;
    logic [KW-1:0] idx, low, act;
    logic [NUM_KEYS-1:0] rem;
    logic [KW:0] push_data, evt;
    assign ps2d = dat_sy[1];
    // an edge counts only after three stable highs then three stable lows
    assign fall = hist == 6'b111000;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            clk_sy <= '1;
            dat_sy <= '1;
            hist <= '1;
        end else begin
            clk_sy <= {clk_sy[0], ps2_clk};
            dat_sy <= {dat_sy[0], ps2_data};
            hist <= {hist[4:0], clk_sy[1]};
        end
    always_comb begin
        state_n = state;
        err = 1'b0;
        done = 1'b0;
        tmo = state != IDLE && !fall && tmr == TW'(TO - 1);
        if (tmo) begin
            state_n = IDLE;
            err = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: state_n = ps2d ? IDLE : DATA;
                DATA: state_n = bit_cnt == 3'd7 ? PARITY : DATA;
                PARITY: state_n = STOP;
                default: begin
                    state_n = IDLE;
                    done = ps2d && (^{sh, par_b});
                    err = !done;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            tmr <= '0;
            bit_cnt <= '0;
            sh <= '0;
            par_b <= 1'b0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_n;
            tmr <= (state == IDLE || fall) ? '0 : tmr + 1'b1;
            bit_cnt <= state == DATA ? bit_cnt + 3'(fall) : 3'd0;
            if (fall && state == DATA) sh <= {ps2d, sh[7:1]};
            if (fall && state == PARITY) par_b <= ps2d;
            rx_valid <= done;
            frame_err <= err;
        end
    // sh holds the received byte until the next frame starts shifting
    always_comb begin
        hit = 1'b0;
        idx = '0;
        low = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (sh == KEY_CODES[8*i +: 8] && ext == EXT_MASK[i]) begin
                hit = 1'b1;
                idx = KW'(i);
            end
        rem = key_state & ~(NUM_KEYS'(1) << idx);
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (rem[i]) low = KW'(i);
        is_key = rx_valid && sh != PFX_EXT && sh != PFX_BRK && hit;
        mk = is_key && !brk && !key_state[idx];
        bk = is_key && brk && key_state[idx];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ext <= 1'b0;
            brk <= 1'b0;
            key_state <= '0;
            act <= '0;
            push <= 1'b0;
            push_data <= '0;
        end else begin
            if (err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                ext <= sh == PFX_EXT || (sh == PFX_BRK && ext);
                brk <= sh == PFX_BRK || (sh == PFX_EXT && brk);
            end
            if (mk) begin
                key_state[idx] <= 1'b1;
                act <= idx;
            end
            if (bk) begin
                key_state[idx] <= 1'b0;
                if (act == idx) act <= low;
            end
            push <= mk || bk;
            push_data <= {idx, mk};
        end
    assign active_valid = |key_state;
    assign active_key = act;
    assign {event_key, event_make} = evt;
    ps2_evt_fifo #(.WIDTH(KW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .din(push_data),
        .pop(event_ready),
        .dout(evt),
        .valid(event_valid),
        .overflow(overflow)
    );
endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter NUM_KEYS, default 4, the number of tracked keys (1..16).
REQ-003 SHALL have parameter KEY_CODES, default {8'h74,8'h6B,8'h72,8'h75}, where key i scan code = KEY_CODES[8i+7:8i] (0 up, 1 down, 2 left, 3 right).
REQ-004 SHALL have parameter EXT_MASK, default 4'b1111, where bit i=1 means key i requires the E0 prefix.
REQ-005 SHALL have parameter TIMEOUT_US, default 100, the maximum gap between ps2_clk falling edges inside a frame.
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, a power of 2, ≥2.
REQ-007 clk  in  1  system clock.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 ps2_clk  in  1  PS/2 clock, asynchronous.
REQ-010 ps2_data  in  1  PS/2 data, asynchronous.
REQ-011 key_state  out  NUM_KEYS  held bitmap, 1=pressed.
REQ-012 active_valid  out  1  at least one key held.
REQ-013 active_key  out  KW=$clog2(NUM_KEYS) (min 1)  selected held key.
REQ-014 event_valid  out  1  FIFO head valid.
REQ-015 event_ready  in  1  consumer accepts head.
REQ-016 event_key  out  KW  key index of head event.
REQ-017 event_make  out  1  1=press, 0=release.
REQ-018 frame_err  out  1  one-cycle pulse on a bad or timed-out frame.
REQ-019 overflow  out  1  sticky; an event was dropped.

Function
REQ-020 ps2_clk/ps2_data SHALL pass 2-flop synchronisers; a falling edge SHALL be accepted only after 3 consecutive high samples followed by 3 consecutive low samples.
REQ-021 Receiver FSM SHALL use states IDLE→DATA(8 bits, LSB first)→PARITY→STOP→IDLE, leaving IDLE on a falling edge that samples data=0.
REQ-022 A frame SHALL be valid only if parity is odd over data+parity and stop=1; otherwise it SHALL be discarded with a frame_err pulse and the prefix flags cleared.
REQ-023 Timeout SHALL be CLK_HZ/1_000_000*TIMEOUT_US cycles; in any non-IDLE state with no accepted edge for that many cycles, the FSM SHALL return to IDLE, pulse frame_err and clear the prefix flags.
REQ-024 Byte E0 SHALL set ext; F0 SHALL set brk; any other byte SHALL be decoded and then clear both flags.
REQ-025 Key i SHALL match when byte==code i and ext==EXT_MASK[i]; the lowest matching index wins; an unmatched byte SHALL be ignored.
REQ-026 On a make with key_state[i]=0: set the bit and push {i,1}; a make with the bit already set (typematic repeat) SHALL cause no change and no push.
REQ-027 On a break with key_state[i]=1: clear the bit and push {i,0}; a break of an unheld key SHALL be ignored.
REQ-028 key_state and the event push SHALL occur 2 clk after the STOP-bit edge is accepted; event_valid SHALL rise on the following cycle if the FIFO was empty.
REQ-029 active_key SHALL be the most recently made key still held; when it is released, it SHALL become the lowest-index held key; active_valid = |key_state.
REQ-030 FIFO SHALL transfer the head on event_valid&&event_ready; a push when full and not popping in the same cycle SHALL be dropped and set overflow; push and pop together when full SHALL both succeed.
REQ-031 event_key and event_make SHALL be stable while event_valid=1 and event_ready=0.

Reset
REQ-032 rst_n low SHALL immediately force key_state=0, active_valid=0, active_key=0, event_valid=0, frame_err=0, overflow=0, FIFO empty, FSM=IDLE, flags clear, and synchronisers to 1.
REQ-033 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL decode normally.

Structure
REQ-034 Package ps2_pkg SHALL hold the receiver state enum, the E0/F0 constants and the default arrow-key code constants.
REQ-035 The FIFO SHALL be a sub-module, ps2_evt_fifo, parametrised by width and depth.

Verification
REQ-036 Frames E0,75 → key_state=4'b0001, event {0,1}, active_key=0; then E0,F0,75 → key_state=0, event {0,0}, active_valid=0.
REQ-037 Press up, press right, release right → active_key goes 0→3→0; three events in order.
REQ-038 Frame 75 with parity bit inverted → frame_err pulse, no state change; bare 75 without E0 → ignored.
REQ-039 Frame aborted after 4 data bits, idle 120 µs → frame_err pulse; the next full frame decodes.
REQ-040 event_ready=0, 10 distinct events → 8 queued, overflow=1, head stable; then drain in order.
REQ-041 rst_n asserted after 5 bits of E0,75 → all outputs at reset values; the next E0,75 → key 0 pressed.
